// File: rtl/serial_tx_arbiter_pkg.sv
// Shared types and constants for the serial TX arbiter: FSM states, sender status polarity,
// byte and index widths, and the round-robin pointer advance rule.
package serial_tx_arbiter_pkg;

  localparam int unsigned ByteW = 8;
  localparam int unsigned IdxW  = 3;

  // Sender status line: 1 means the sender is idle and can take a byte.
  localparam logic TxStatusIdle = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StBusy = 2'd2
  } state_e;

  // Pointer after a grant to `owner`; with fixed priority on index 0 it wraps to 1, not 0.
  function automatic logic [IdxW-1:0] rr_next(input logic [IdxW-1:0] owner,
                                               input int unsigned     n_req,
                                               input logic            prio_en);
    int unsigned nxt;
    nxt = 32'(owner) + 32'd1;
    if (nxt >= n_req) begin
      nxt = prio_en ? 32'd1 : 32'd0;
    end
    return nxt[IdxW-1:0];
  endfunction

endpackage

// File: rtl/serial_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping.
// With i_prio_en set, requester 0 always wins and is excluded from the rotating scan.
module serial_tx_arbiter_rr_picker
  import serial_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IdxW-1:0]  i_rr_ptr,
  input  logic             i_prio_en,
  output logic             o_valid,
  output logic [IdxW-1:0]  o_winner
);

  logic [N_REQ-1:0] w_rr_mask;

  always_comb begin
    w_rr_mask = i_req;
    if (i_prio_en) begin
      w_rr_mask[0] = 1'b0;
    end
  end

  // Two passes: indices at/after the pointer first, then the wrapped-around lower indices.
  always_comb begin
    o_valid  = 1'b0;
    o_winner = '0;
    if (i_prio_en && i_req[0]) begin
      o_valid  = 1'b1;
      o_winner = '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!o_valid && w_rr_mask[i] && (i >= 32'(i_rr_ptr))) begin
          o_valid  = 1'b1;
          o_winner = IdxW'(i);
        end
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!o_valid && w_rr_mask[i]) begin
          o_valid  = 1'b1;
          o_winner = IdxW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Shares one UART byte sender among N_REQ requesters, one byte per round-robin grant.
// Define SERIAL_TX_ARB_PRIO_EN to give requester 0 fixed top priority over the rotation.
module serial_tx_arbiter
  import serial_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned WAIT_TIMEOUT = 20000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [ByteW*N_REQ-1:0] i_req_data,
  output logic [N_REQ-1:0]       o_ack,
  output logic                   o_err,
  output logic [IdxW-1:0]        o_owner,
  output logic                   o_busy,
  output logic [ByteW-1:0]       o_tx_data,
  output logic                   o_tx_en,
  input  logic                   i_tx_status
);

  localparam int unsigned CntW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_TIMEOUT - 1);

`ifdef SERIAL_TX_ARB_PRIO_EN
  localparam logic PrioEn = 1'b1;
`else
  localparam logic PrioEn = 1'b0;
`endif

  // Under fixed priority the rotation covers 1..N_REQ-1 only, so the pointer starts at 1.
  localparam logic [IdxW-1:0] RrPtrRst = {{(IdxW-1){1'b0}}, PrioEn};

  state_e            r_state;
  logic              r_tx_en;
  logic [ByteW-1:0]  r_tx_data;
  logic [N_REQ-1:0]  r_ack;
  logic              r_err;
  logic [IdxW-1:0]   r_owner;
  logic [IdxW-1:0]   r_rr_ptr;
  logic [CntW-1:0]   r_cnt;

  state_e            w_state_d;
  logic              w_tx_en_d;
  logic [ByteW-1:0]  w_tx_data_d;
  logic [N_REQ-1:0]  w_ack_d;
  logic              w_err_d;
  logic [IdxW-1:0]   w_owner_d;
  logic [IdxW-1:0]   w_rr_ptr_d;
  logic [CntW-1:0]   w_cnt_d;

  logic              w_pick_valid;
  logic [IdxW-1:0]   w_pick_idx;
  logic [ByteW-1:0]  w_pick_data;
  logic [N_REQ-1:0]  w_owner_oh;
  logic              w_sender_idle;

  serial_tx_arbiter_rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .i_req     (i_req),
    .i_rr_ptr  (r_rr_ptr),
    .i_prio_en (PrioEn),
    .o_valid   (w_pick_valid),
    .o_winner  (w_pick_idx)
  );

  assign w_sender_idle = (i_tx_status == TxStatusIdle);

  always_comb begin
    w_pick_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_pick_idx == IdxW'(i)) begin
        w_pick_data = i_req_data[ByteW*i +: ByteW];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_owner_oh[i] = (r_owner == IdxW'(i));
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_tx_en_d   = r_tx_en;
    w_tx_data_d = r_tx_data;
    w_ack_d     = '0;
    w_err_d     = 1'b0;
    w_owner_d   = r_owner;
    w_rr_ptr_d  = r_rr_ptr;
    w_cnt_d     = r_cnt;
    unique case (r_state)
      StIdle: begin
        // Grant only when the sender is idle; the byte is captured here and never re-sampled.
        if (w_pick_valid && w_sender_idle) begin
          w_state_d   = StLoad;
          w_tx_en_d   = 1'b1;
          w_tx_data_d = w_pick_data;
          w_owner_d   = w_pick_idx;
          w_cnt_d     = '0;
        end
      end
      StLoad: begin
        w_cnt_d = r_cnt + 1'b1;
        if (!w_sender_idle) begin
          w_tx_en_d = 1'b0;
          w_ack_d   = w_owner_oh;
          w_state_d = StBusy;
        end else if (r_cnt == CntLast) begin
          w_tx_en_d  = 1'b0;
          w_err_d    = 1'b1;
          w_rr_ptr_d = rr_next(r_owner, N_REQ, PrioEn);
          w_state_d  = StIdle;
        end
      end
      StBusy: begin
        if (w_sender_idle) begin
          w_rr_ptr_d = rr_next(r_owner, N_REQ, PrioEn);
          w_state_d  = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_tx_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
      r_ack     <= '0;
      r_err     <= 1'b0;
      r_owner   <= '0;
      r_rr_ptr  <= RrPtrRst;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_d;
      r_tx_en   <= w_tx_en_d;
      r_tx_data <= w_tx_data_d;
      r_ack     <= w_ack_d;
      r_err     <= w_err_d;
      r_owner   <= w_owner_d;
      r_rr_ptr  <= w_rr_ptr_d;
      r_cnt     <= w_cnt_d;
    end
  end

  assign o_ack     = r_ack;
  assign o_err     = r_err;
  assign o_owner   = r_owner;
  assign o_busy    = (r_state != StIdle);
  assign o_tx_data = r_tx_data;
  assign o_tx_en   = r_tx_en;

  // ack and err never coincide, and at most one requester is acked per cycle.
  a_ack_err_excl: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(|r_ack && r_err));
  a_ack_onehot:   assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(r_ack));

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: directed scenarios plus random traffic against a sender model,
// with a grant-time reference pick feeding a scoreboard checked on every ack/err.
module tb_serial_tx_arbiter;

  localparam int NReq      = 4;
  localparam int WaitTo    = 50;
  localparam int AcceptDly = 3;
  localparam int BusyLen   = 20;
`ifdef SERIAL_TX_ARB_PRIO_EN
  localparam bit Prio = 1'b1;
`else
  localparam bit Prio = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NReq-1:0]   req;
  logic [8*NReq-1:0] req_data;
  logic [NReq-1:0]   ack;
  logic              err;
  logic [2:0]        owner;
  logic              busy;
  logic [7:0]        tx_data;
  logic              tx_en;
  logic              tx_status;

  typedef struct {
    int         idx;
    logic [7:0] data;
    bit         is_err;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] sent_q[$];
  int         grant_log[$];
  int         n_checks = 0;
  int         n_errors = 0;
  bit         stuck = 1'b0;
  bit         force_busy = 1'b0;
  bit [NReq-1:0] cont = '0;
  int         m_ptr = 0;
  int         s_en_cnt = 0;
  int         s_busy_left = 0;

  serial_tx_arbiter #(
    .N_REQ        (NReq),
    .WAIT_TIMEOUT (WaitTo)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_req_data  (req_data),
    .o_ack       (ack),
    .o_err       (err),
    .o_owner     (owner),
    .o_busy      (busy),
    .o_tx_data   (tx_data),
    .o_tx_en     (tx_en),
    .i_tx_status (tx_status)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference arbitration: requester 0 first under priority, else first pending from ptr on.
  function automatic int model_pick(input logic [NReq-1:0] r, input int ptr);
    if (Prio && r[0]) return 0;
    for (int k = 0; k < NReq; k++) begin
      int i;
      i = (ptr + k) % NReq;
      if (!(Prio && i == 0) && r[i]) return i;
    end
    return -1;
  endfunction

  // Sender: accepts after tx_en has been high AcceptDly cycles, then stays busy BusyLen cycles.
  initial begin
    tx_status = 1'b1;
    forever begin
      @(negedge clk);
      if (s_busy_left > 0) begin
        s_busy_left--;
      end else if (tx_en === 1'b1 && !stuck) begin
        s_en_cnt++;
        if (s_en_cnt == AcceptDly) begin
          sent_q.push_back(tx_data);
          s_busy_left = BusyLen;
          s_en_cnt    = 0;
        end
      end else begin
        s_en_cnt = 0;
      end
      tx_status = !(s_busy_left > 0 || force_busy);
    end
  end

  // Monitor: records expectations at each grant and pops them on every ack/err.
  initial begin
    int   en_len;
    bit   prev_en;
    int   w;
    exp_t e;
    en_len  = 0;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        sent_q.delete();
        m_ptr   = 0;
        en_len  = 0;
        prev_en = 1'b0;
        chk("reset_outputs", {tx_data, owner, ack, err, busy, tx_en}, 32'd0);
        continue;
      end
      if (|ack || err) begin
        chk("ack_err_exclusive", {31'd0, (|ack) & err}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_handshake", {ack, err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("handshake_kind", {ack, err}, e.is_err ? 32'd1 : (32'd1 << (e.idx + 1)));
          chk("tx_en_high_len", en_len, e.is_err ? WaitTo : AcceptDly);
          if (!e.is_err) begin
            chk("sender_byte_count", sent_q.size(), 32'd1);
            if (sent_q.size() > 0) chk("sender_byte", sent_q.pop_front(), e.data);
          end
        end
      end
      if (tx_en && !prev_en) begin
        w = model_pick(req, m_ptr);
        chk("grant_owner", owner, w);
        if (w >= 0) begin
          chk("grant_data", tx_data, req_data[8*w +: 8]);
          exp_q.push_back('{w, req_data[8*w +: 8], stuck});
          grant_log.push_back(w);
          m_ptr = (w + 1) % NReq;
        end
      end
      en_len  = tx_en ? en_len + 1 : 0;
      prev_en = tx_en;
    end
  end

  // Advance one cycle; drive after the negedge so the monitor samples settled values first.
  task automatic tick();
    @(negedge clk);
    #2;
    for (int i = 0; i < NReq; i++) begin
      if (req[i] && (ack[i] || (err && owner == 3'(i)))) begin
        req[i] = 1'b0;
        if (cont[i]) begin
          req[i]              = 1'b1;
          req_data[8*i +: 8]  = 8'($urandom);
        end
      end
    end
  endtask

  task automatic rand_step();
    for (int i = 0; i < NReq; i++) begin
      if (!req[i] && $urandom_range(0, 7) == 0) begin
        req_data[8*i +: 8] = 8'($urandom);
        req[i]             = 1'b1;
      end
    end
    // Owner changes its data after the grant; the byte in flight must not follow.
    if (busy && req[owner]) req_data[8*owner +: 8] = 8'($urandom);
  endtask

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    while ((req != '0 || busy || exp_q.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    chk(name, {31'd0, n < 3000}, 32'd1);
    tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single request: one-cycle latency, data/owner, busy drops after sender returns idle.
    req_data[23:16] = 8'hA5;
    req[2]          = 1'b1;
    tick();
    chk("s1_tx_en", tx_en, 32'd1);
    chk("s1_tx_data", tx_data, 32'hA5);
    chk("s1_owner", owner, 32'd2);
    for (int n = 0; n < 100 && req[2]; n++) tick();
    chk("s1_acked", req[2], 32'd0);
    for (int n = 0; n < 100 && !tx_status; n++) tick();
    chk("s1_sender_idle", tx_status, 32'd1);
    chk("s1_busy_hold", busy, 32'd1);
    tick();
    chk("s1_busy_fall", busy, 32'd0);
    wait_quiet("s1_quiet");

    // Sender never accepts: tx_en held WaitTo cycles, err, then requester 2 is next.
    stuck           = 1'b1;
    req_data[15:8]  = 8'h5A;
    req[1]          = 1'b1;
    tick();
    chk("s3_owner", owner, 32'd1);
    req_data[23:16] = 8'h77;
    req[2]          = 1'b1;
    for (int n = 0; n < 200 && req[1]; n++) tick();
    chk("s3_dropped", req[1], 32'd0);
    chk("s3_tx_en_low", tx_en, 32'd0);
    stuck = 1'b0;
    tick();
    chk("s3_next_en", tx_en, 32'd1);
    chk("s3_next_owner", owner, 32'd2);
    wait_quiet("s3_quiet");

    // Reset during LOAD.
    req_data[31:24] = 8'hC3;
    req[3]          = 1'b1;
    tick();
    chk("s4_granted", tx_en, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("s4_tx_en", tx_en, 32'd0);
    chk("s4_busy", busy, 32'd0);
    chk("s4_owner", owner, 32'd0);
    rst_n  = 1'b1;
    req[3] = 1'b0;
    tick();
    chk("s4_no_handshake", {ack, err, tx_en}, 32'd0);
    wait_quiet("s4_quiet");

    // Sender busy from elsewhere: no grant until it returns idle, then grant next edge.
    force_busy = 1'b1;
    tick();
    req_data[31:24] = 8'h3C;
    req[3]          = 1'b1;
    repeat (5) begin
      tick();
      chk("s5_no_grant", tx_en, 32'd0);
    end
    force_busy = 1'b0;
    tick();
    chk("s5_wait_edge", tx_en, 32'd0);
    tick();
    chk("s5_grant", tx_en, 32'd1);
    chk("s5_owner", owner, 32'd3);
    wait_quiet("s5_quiet");

    // Contention: all four at once, then again to show the wrap back to requester 0.
    grant_log.delete();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req      = 4'hF;
    wait_quiet("s2_quiet_a");
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req      = 4'hF;
    wait_quiet("s2_quiet_b");
    chk("s2_count", grant_log.size(), 32'd8);
    for (int k = 0; k < 5 && k < grant_log.size(); k++) chk("s2_order", grant_log[k], k % 4);

    // Requesters 0 and 1 continuously: alternate, or 0 every time with fixed priority.
    grant_log.delete();
    cont     = 4'b0011;
    req[0]   = 1'b1;
    req[1]   = 1'b1;
    for (int n = 0; n < 400 && grant_log.size() < 6; n++) tick();
    cont = '0;
    wait_quiet("s6_quiet");
    chk("s6_count_min", {31'd0, grant_log.size() >= 6}, 32'd1);
    for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
      chk("s6_sequence", grant_log[k], Prio ? 0 : k % 2);
    end

    // Random traffic.
    for (int n = 0; n < 900; n++) begin
      tick();
      rand_step();
    end
    wait_quiet("rand_quiet");

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    chk("sender_queue_drained", sent_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
